seq_event_logger: RTL and testbench

Downstream consumer of the serial sequence detector's `seq_det` output. Converts each detection into one event, timestamps it against a free-running cycle counter, and queues the timestamps in a small FIFO that software or a later stage drains through a valid/ready port. Also keeps a saturating event count and a sticky overflow flag for dropped events.

---
 rtl/seq_pkg.sv | 6 +
 rtl/ts_fifo.sv | 56 +++++
 rtl/seq_event_logger.sv | 87 ++++++++
 tb/tb_seq_event_logger.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared defaults for the sequence detector and its event logger
package seq_pkg;
    localparam int SEQ_TS_W     = 16;
    localparam int SEQ_CNT_W    = 8;
    localparam int SEQ_EV_DEPTH = 4;
endpackage

// File: rtl/ts_fifo.sv
// rtl/ts_fifo.sv - timestamp FIFO, extra pointer bit distinguishes full from empty
module ts_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: rtl/seq_event_logger.sv
// rtl/seq_event_logger.sv - timestamps detector rising edges into a drainable FIFO
module seq_event_logger
    import seq_pkg::*;
#(
    parameter int TS_W  = SEQ_TS_W,
    parameter int DEPTH = SEQ_EV_DEPTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     det_in,
    input  logic                     clr,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [TS_W-1:0]          ev_ts,
    output logic [CNT_W-1:0]         ev_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam logic [TS_W-1:0]  TS_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  r_ts;
    logic             r_det_q;
    logic [CNT_W-1:0] r_ev_count;
    logic             r_overflow;
    logic             w_event;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;

    // clr masks both the event and the pop so the flush wins outright.
    assign w_event = det_in & ~r_det_q & ~clr;
    assign w_pop   = ~w_empty & ev_ready & ~clr;
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    assign ev_valid = ~w_empty;
    assign ev_count = r_ev_count;
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts    <= '0;
            r_det_q <= 1'b0;
        end else begin
            r_ts    <= r_ts + TS_ONE;
            r_det_q <= det_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_count <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_ev_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_event && (r_ev_count != CNT_MAX)) begin
                r_ev_count <= r_ev_count + CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_ts),
        .dout  (ev_ts),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );
endmodule

// File: tb/tb_seq_event_logger.sv
// tb/tb_seq_event_logger.sv - directed scoreboard bench for seq_event_logger
module tb_seq_event_logger;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        det_in, clr, ev_ready;
    logic        ev_valid, overflow;
    logic [15:0] ev_ts;
    logic [7:0]  ev_count;
    logic [2:0]  fifo_level;

    logic        det_s, clr_s, rdy_s;
    logic        valid_s, ovf_s;
    logic [3:0]  ts_s;
    logic [1:0]  cnt_s;
    logic [2:0]  lvl_s;

    int unsigned m_ts;
    logic [15:0] q[$];
    logic [3:0]  qs[$];
    int          n_asrt = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    int          ns = 0;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    seq_event_logger dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .det_in     (det_in),
        .clr        (clr),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_ts      (ev_ts),
        .ev_count   (ev_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    seq_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .det_in     (det_s),
        .clr        (clr_s),
        .ev_ready   (rdy_s),
        .ev_valid   (valid_s),
        .ev_ts      (ts_s),
        .ev_count   (cnt_s),
        .overflow   (ovf_s),
        .fifo_level (lvl_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= 0;
        else        m_ts <= m_ts + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        det_in = 1'b1;
        if (q.size() < 4) q.push_back(m_ts[15:0]);
        else exp_ovf = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
        step();
        det_in = 1'b0;
    endtask

    task automatic drain_one();
        logic [15:0] e;
        chk("drain_valid", {31'd0, ev_valid}, 32'd1);
        e = q.pop_front();
        chk("drain_ts", {16'd0, ev_ts}, {16'd0, e});
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        q.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; det_in = 1'b0; clr = 1'b0; ev_ready = 1'b0;
        det_s = 1'b0; clr_s = 1'b0; rdy_s = 1'b0;
        step(); step();
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_ts",    {16'd0, ev_ts}, 32'd0);
        chk("rst_count", {24'd0, ev_count}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        rst_n = 1'b1;

        // single pulse at cycle 5
        repeat (5) step();
        pulse();
        chk("p1_valid", {31'd0, ev_valid}, 32'd1);
        chk("p1_ts",    {16'd0, ev_ts}, 32'd5);
        chk("p1_count", {24'd0, ev_count}, 32'd1);
        chk("p1_level", {29'd0, fifo_level}, 32'd1);
        drain_one();
        chk("p1_empty", {31'd0, ev_valid}, 32'd0);

        // held level gives one event
        do_clr();
        det_in = 1'b1;
        q.push_back(m_ts[15:0]);
        exp_cnt = 1;
        repeat (11) step();
        det_in = 1'b0;
        step();
        chk("hold_level", {29'd0, fifo_level}, 32'd1);
        chk("hold_count", {24'd0, ev_count}, exp_cnt);
        drain_one();
        chk("hold_empty", {29'd0, fifo_level}, 32'd0);

        // overflow with consumer stalled
        do_clr();
        for (int i = 0; i < 5; i++) begin
            pulse();
            if (i == 3) chk("ovf_before", {31'd0, overflow}, 32'd0);
            step(); step();
        end
        chk("ovf_level", {29'd0, fifo_level}, 32'd4);
        chk("ovf_flag",  {31'd0, overflow}, {31'd0, exp_ovf});
        chk("ovf_count", {24'd0, ev_count}, exp_cnt);
        for (int i = 0; i < 4; i++) drain_one();
        chk("ovf_drained", {31'd0, ev_valid}, 32'd0);
        chk("ovf_sticky",  {31'd0, overflow}, 32'd1);

        // full FIFO, event coincides with pop
        do_clr();
        for (int i = 0; i < 4; i++) begin
            pulse();
            step();
        end
        chk("fp_full", {29'd0, fifo_level}, 32'd4);
        det_in = 1'b1;
        ev_ready = 1'b1;
        begin
            logic [15:0] e;
            e = q.pop_front();
            chk("fp_head", {16'd0, ev_ts}, {16'd0, e});
        end
        q.push_back(m_ts[15:0]);
        exp_cnt++;
        step();
        det_in = 1'b0;
        ev_ready = 1'b0;
        chk("fp_ovf",   {31'd0, overflow}, 32'd0);
        chk("fp_level", {29'd0, fifo_level}, 32'd4);
        chk("fp_count", {24'd0, ev_count}, exp_cnt);
        for (int i = 0; i < 4; i++) drain_one();

        // clr beats a simultaneous event
        do_clr();
        pulse(); step();
        pulse(); step();
        chk("cp_level2", {29'd0, fifo_level}, 32'd2);
        det_in = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        q.delete();
        chk("cp_level", {29'd0, fifo_level}, 32'd0);
        chk("cp_count", {24'd0, ev_count}, 32'd0);
        chk("cp_ovf",   {31'd0, overflow}, 32'd0);
        chk("cp_valid", {31'd0, ev_valid}, 32'd0);
        repeat (3) step();
        chk("cp_noretrig_lvl", {29'd0, fifo_level}, 32'd0);
        chk("cp_noretrig_cnt", {24'd0, ev_count}, 32'd0);
        det_in = 1'b0;
        step();

        // narrow instance: ts wrap and count saturation
        for (int i = 0; i < 6; i++) begin
            logic [3:0] e;
            det_s = 1'b1;
            qs.push_back(m_ts[3:0]);
            ns++;
            step();
            det_s = 1'b0;
            chk("sw_valid", {31'd0, valid_s}, 32'd1);
            e = qs.pop_front();
            chk("sw_ts",    {28'd0, ts_s}, {28'd0, e});
            chk("sw_count", {30'd0, cnt_s}, (ns > 3) ? 32'd3 : ns);
            rdy_s = 1'b1;
            step();
            rdy_s = 1'b0;
            step();
        end
        chk("sw_sat", {30'd0, cnt_s}, 32'd3);

        // asynchronous reset mid-drain
        det_s = 1'b1; det_in = 1'b1;
        step();
        det_s = 1'b0; det_in = 1'b0;
        step();
        det_s = 1'b1; det_in = 1'b1;
        step();
        det_s = 1'b0; det_in = 1'b0;
        chk("mr_level", {29'd0, lvl_s}, 32'd2);
        rdy_s = 1'b1;
        step();
        rdy_s = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mr_valid",   {31'd0, ev_valid}, 32'd0);
        chk("mr_ts",      {16'd0, ev_ts}, 32'd0);
        chk("mr_count",   {24'd0, ev_count}, 32'd0);
        chk("mr_level_m", {29'd0, fifo_level}, 32'd0);
        chk("mr_s_valid", {31'd0, valid_s}, 32'd0);
        chk("mr_s_ts",    {28'd0, ts_s}, 32'd0);
        chk("mr_s_count", {30'd0, cnt_s}, 32'd0);
        chk("mr_s_ovf",   {31'd0, ovf_s}, 32'd0);
        chk("mr_s_level", {29'd0, lvl_s}, 32'd0);
        q.delete();
        qs.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
